gigamax_bus_arbiter: RTL and testbench

Central bus arbiter for the Gigamax coherence bus. It sits directly upstream of the processor and memory agents. Each cycle it grants mastership to at most one agent, drives the selected agent's command onto the shared bus, ORs the agents' snoop replies, and computes the bus-wide abort. Aborted transactions are retried by the same master, up to a retry limit.

---
 rtl/gigamax_pkg.sv | 31 +++
 rtl/gigamax_rr_pick.sv | 32 +++
 rtl/gigamax_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_gigamax_bus_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gigamax_pkg.sv
// Shared types for the Gigamax coherence bus: command/status encodings,
// arbiter FSM states and the read-command helper.
package gigamax_pkg;

  typedef enum logic [3:0] {
    CMD_IDLE               = 4'd0,
    CMD_READ_SHARED        = 4'd1,
    CMD_READ_OWNED         = 4'd2,
    CMD_WRITE_INVALID      = 4'd3,
    CMD_WRITE_SHARED       = 4'd4,
    CMD_WRITE_RESP_INVALID = 4'd5,
    CMD_WRITE_RESP_SHARED  = 4'd6,
    CMD_INVALIDATE         = 4'd7,
    CMD_RESPONSE           = 4'd8
  } command_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_OWNED   = 2'd1,
    ST_WAITING = 2'd2,
    ST_STALL   = 2'd3
  } status_t;

  typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

  // Reads are the only commands a waiting reply can abort.
  function automatic logic CMD_IS_READ(input logic [3:0] c);
    return (c == CMD_READ_SHARED) || (c == CMD_READ_OWNED);
  endfunction

endpackage

// File: rtl/gigamax_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module gigamax_rr_pick
  import gigamax_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx
);

  int c;

  always_comb begin
    valid = 1'b0;
    win   = '0;
    idx   = '0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        win[c] = 1'b1;
        idx    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/gigamax_bus_arbiter.sv
// Gigamax bus arbiter: round-robin grant FSM with abort/retry limit.
// Define GIGAMAX_ARB_MEM_PRIO_EN to let memory (agent N_AGT-1) always win arbitration.
module gigamax_bus_arbiter
  import gigamax_pkg::*;
#(
  parameter int N_AGT     = 4,
  parameter int MAX_RETRY = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_AGT-1:0]   req,
  input  logic [4*N_AGT-1:0] cmd_in,
  input  logic [N_AGT-1:0]   rep_owned,
  input  logic [N_AGT-1:0]   rep_waiting,
  input  logic [N_AGT-1:0]   rep_stall,
  output logic [N_AGT-1:0]   master,
  output logic [3:0]         CMD,
  output logic               REPLY_OWNED,
  output logic               REPLY_WAITING,
  output logic               REPLY_STALL,
  output logic               abort,
  output logic               retry_err
);

  localparam int PW = (N_AGT > 1) ? $clog2(N_AGT) : 1;
  localparam logic [PW-1:0] LAST  = PW'(N_AGT - 1);
  localparam logic [3:0]    RLAST = 4'(MAX_RETRY - 1);

  state_t                     state, state_n;
  logic [N_AGT-1:0]           master_n;
  logic [PW-1:0]              gidx, gidx_n, ptr, ptr_n, nxt_ptr, base_ptr, pick_ptr, pick_idx;
  logic [3:0]                 retry_cnt, retry_n;
  logic                       err_n, pick_vld;
  logic [N_AGT-1:0]           pick_win;
  logic [N_AGT-1:0][3:0]      cmd_arr;

  assign cmd_arr       = cmd_in;
  assign CMD           = (master != '0) ? cmd_arr[gidx] : CMD_IDLE;
  assign REPLY_OWNED   = |rep_owned;
  assign REPLY_WAITING = |rep_waiting;
  assign REPLY_STALL   = |rep_stall;
  assign abort         = REPLY_STALL | (CMD_IS_READ(CMD) & REPLY_WAITING);

  // On a commit the new grant is picked from the already-advanced pointer.
  assign nxt_ptr  = (gidx == LAST) ? '0 : gidx + 1'b1;
  assign base_ptr = (state == S_BUS) ? nxt_ptr : ptr;
`ifdef GIGAMAX_ARB_MEM_PRIO_EN
  assign pick_ptr = req[N_AGT-1] ? LAST : base_ptr;
`else
  assign pick_ptr = base_ptr;
`endif

  gigamax_rr_pick #(.N(N_AGT), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_vld),
    .win   (pick_win),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      master    <= '0;
      gidx      <= '0;
      ptr       <= '0;
      retry_cnt <= '0;
      retry_err <= 1'b0;
    end else begin
      state     <= state_n;
      master    <= master_n;
      gidx      <= gidx_n;
      ptr       <= ptr_n;
      retry_cnt <= retry_n;
      retry_err <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    master_n = master;
    gidx_n   = gidx;
    ptr_n    = ptr;
    retry_n  = retry_cnt;
    err_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          master_n = pick_win;
          gidx_n   = pick_idx;
          state_n  = S_BUS;
        end
      end
      S_BUS: begin
        if (abort) begin
          if (retry_cnt == RLAST) begin
            err_n    = 1'b1;
            retry_n  = '0;
            ptr_n    = nxt_ptr;
            master_n = '0;
            state_n  = S_IDLE;
          end else begin
            retry_n = retry_cnt + 4'd1;
          end
        end else begin
          ptr_n   = nxt_ptr;
          retry_n = '0;
          if (pick_vld) begin
            master_n = pick_win;
            gidx_n   = pick_idx;
          end else begin
            master_n = '0;
            state_n  = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gigamax_bus_arbiter.sv
// Self-checking bench: directed table, retry/reset sequences, random traffic vs reference model.
module tb_gigamax_bus_arbiter;

  localparam int N  = 4;
  localparam int MR = 7;
`ifdef GIGAMAX_ARB_MEM_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]   req, rep_owned, rep_waiting, rep_stall;
  logic [4*N-1:0] cmd_in;
  logic [N-1:0]   master;
  logic [3:0]     CMD;
  logic REPLY_OWNED, REPLY_WAITING, REPLY_STALL, abort, retry_err;

  gigamax_bus_arbiter #(.N_AGT(N), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd_in(cmd_in),
    .rep_owned(rep_owned), .rep_waiting(rep_waiting), .rep_stall(rep_stall),
    .master(master), .CMD(CMD), .REPLY_OWNED(REPLY_OWNED),
    .REPLY_WAITING(REPLY_WAITING), .REPLY_STALL(REPLY_STALL),
    .abort(abort), .retry_err(retry_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  // Reference model: who holds the bus (-1 = nobody), rotation pointer, abort count.
  int m_gnt = -1;
  int m_ptr = 0;
  int m_rc  = 0;
  bit m_err = 1'b0;

  typedef struct {
    logic [N-1:0] req, own, wt, st;
    int xm, xc, xa, xe;
  } vec_t;
  vec_t tbl[11];

  function automatic int winner(input logic [N-1:0] r, input int p);
    if (PRIO && r[N-1]) return N - 1;
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int slice(input logic [4*N-1:0] c, input int i);
    return int'(c[4*i +: 4]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Compare at negedge against the model (and optional table values), then advance the model at posedge.
  task automatic tick(input string nm, input int xm, input int xc, input int xa, input int xe);
    int em, ec, ea;
    @(negedge clk);
    em = (m_gnt < 0) ? 0 : (1 << m_gnt);
    ec = (m_gnt < 0) ? 0 : slice(cmd_in, m_gnt);
    ea = ((rep_stall != 0) || (((ec == 1) || (ec == 2)) && (rep_waiting != 0))) ? 1 : 0;
    chk({nm, ".master"}, 32'(master), 32'(em));
    chk({nm, ".cmd"}, 32'(CMD), 32'(ec));
    chk({nm, ".owned"}, 32'(REPLY_OWNED), 32'(rep_owned != 0));
    chk({nm, ".waiting"}, 32'(REPLY_WAITING), 32'(rep_waiting != 0));
    chk({nm, ".stall"}, 32'(REPLY_STALL), 32'(rep_stall != 0));
    chk({nm, ".abort"}, 32'(abort), 32'(ea));
    chk({nm, ".retry_err"}, 32'(retry_err), 32'(m_err));
    if (xm >= 0) chk({nm, ".tbl_master"}, 32'(master), 32'(xm));
    if (xc >= 0) chk({nm, ".tbl_cmd"}, 32'(CMD), 32'(xc));
    if (xa >= 0) chk({nm, ".tbl_abort"}, 32'(abort), 32'(xa));
    if (xe >= 0) chk({nm, ".tbl_err"}, 32'(retry_err), 32'(xe));
    @(posedge clk);
    m_err = 1'b0;
    if (!rst_n) begin
      m_gnt = -1; m_ptr = 0; m_rc = 0;
    end else if (m_gnt < 0) begin
      m_gnt = winner(req, m_ptr);
    end else if (ea != 0) begin
      if (m_rc == MR - 1) begin
        m_err = 1'b1; m_rc = 0; m_ptr = (m_gnt + 1) % N; m_gnt = -1;
      end else begin
        m_rc++;
      end
    end else begin
      m_ptr = (m_gnt + 1) % N; m_rc = 0;
      m_gnt = winner(req, m_ptr);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rep_owned = '0; rep_waiting = '0; rep_stall = '0;
    repeat (2) @(posedge clk);
    m_gnt = -1; m_ptr = 0; m_rc = 0; m_err = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // agent0=read_shared, agent1=write_shared, agent2=read_owned, agent3=response
    cmd_in = 16'h8241;
    tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 4, 0, 0};
    tbl[2]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
    tbl[3]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4, 2, 0, 0};
    tbl[4]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0};
    tbl[5]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 2, 4, 0, 0};
    tbl[6]  = '{4'b0111, 4'b0000, 4'b0010, 4'b0000, 4, 2, 1, 0};
    tbl[7]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4, 2, 0, 0};
    tbl[8]  = '{4'b0111, 4'b0100, 4'b0000, 4'b0000, 1, 1, 0, 0};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 2, 4, 0, 0};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req; rep_owned = tbl[i].own; rep_waiting = tbl[i].wt; rep_stall = tbl[i].st;
      tick($sformatf("tbl%0d", i), tbl[i].xm, tbl[i].xc, tbl[i].xa, tbl[i].xe);
    end

    // Retry limit: agent 0 stalled until the grant is revoked.
    do_reset();
    req = 4'b0011;
    tick("st_arb", 0, 0, 0, 0);
    rep_stall = 4'b0100;
    for (int i = 0; i < MR; i++) tick($sformatf("st_abort%0d", i), 1, 1, 1, 0);
    tick("st_err", 0, 0, -1, 1);
    rep_stall = '0;
    tick("st_next", 2, 4, 0, 0);

    // Reset in the middle of a retry run.
    rep_stall = 4'b0100;
    tick("rm_abort0", 1, 1, 1, 0);
    tick("rm_abort1", 1, 1, 1, 0);
    rst_n = 1'b0;
    tick("rm_rst", 1, 1, 1, 0);
    rst_n = 1'b1; rep_stall = '0; req = 4'b1001;
    tick("rm_after", 0, 0, 0, 0);
    tick("prio", PRIO ? 8 : 1, PRIO ? 8 : 1, 0, 0);

    // Random traffic, alternating sparse-stall and heavy-stall phases.
    for (int c = 0; c < 400; c++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      req         = N'($urandom);
      cmd_in      = (4*N)'($urandom);
      rep_owned   = N'($urandom);
      rep_waiting = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      if (((c / 50) % 2) == 1)
        rep_stall = ($urandom_range(0, 7) != 0) ? 4'b1000 : '0;
      else
        rep_stall = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      tick("rand", -1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
